// File: rtl/mux_scan_pkg.sv
// +--------------------------------------------------------------------------+
// | mux_scan_pkg : shared constants, state type and bit-search helper.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package mux_scan_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } scan_state_t;

  // Descending walk so the lowest set index is the one left standing.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chan_next_find.sv
// +--------------------------------------------------------------------------+
// | chan_next_find : lowest enabled channel strictly above the current one.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module chan_next_find
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    // No wrap-around: only indices above cur are candidates.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) > {1'b0, cur})) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | mux_scan_ctrl : walks a 16:1 mux select over enabled channels, samples    |
// | each after a dwell time and presents the frame on a valid/ready port.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   chan_mask,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_DWELL_LAST = CNT_W'(DWELL - 1);

  scan_state_t      r_state,  w_state_n;
  logic [SEL_W-1:0] r_sel,    w_sel_n;
  logic [CNT_W-1:0] r_cnt,    w_cnt_n;
  logic [NCH-1:0]   r_mask,   w_mask_n;
  logic [NCH-1:0]   r_shadow, w_shadow_n;
  logic [NCH-1:0]   r_data,   w_data_n;
  logic             r_valid,  w_valid_n;
  logic             r_busy,   w_busy_n;

  logic [SEL_W-1:0] w_nxt;
  logic             w_found;

  chan_next_find u_next (
    .mask  (r_mask),
    .cur   (r_sel),
    .nxt   (w_nxt),
    .found (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sel    <= w_sel_n;
      r_cnt    <= w_cnt_n;
      r_mask   <= w_mask_n;
      r_shadow <= w_shadow_n;
      r_data   <= w_data_n;
      r_valid  <= w_valid_n;
      r_busy   <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_sel_n    = r_sel;
    w_cnt_n    = r_cnt;
    w_mask_n   = r_mask;
    w_shadow_n = r_shadow;
    w_data_n   = r_data;
    w_valid_n  = r_valid;
    w_busy_n   = r_busy;

    case (r_state)
      IDLE: begin
        w_sel_n  = '0;
        w_busy_n = 1'b0;
        if (start) begin
          w_mask_n   = chan_mask;
          w_shadow_n = '0;
          w_cnt_n    = '0;
          w_busy_n   = 1'b1;
          if (chan_mask != '0) begin
            w_state_n = SETTLE;
            w_sel_n   = lowest_set(chan_mask);
          end else begin
            w_state_n = PRESENT;
            w_data_n  = '0;
            w_valid_n = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (r_cnt == C_DWELL_LAST) begin
          w_shadow_n[r_sel] = mux_out;
          w_cnt_n           = '0;
          if (w_found) begin
            w_sel_n = w_nxt;
          end else begin
            w_data_n  = w_shadow_n;
            w_valid_n = 1'b1;
            w_state_n = PRESENT;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end

      PRESENT: begin
        if (r_valid && frame_ready) begin
          if (cont) begin
            // Rescan straight from the handshake edge with the held mask.
            w_cnt_n    = '0;
            w_shadow_n = '0;
            if (r_mask != '0) begin
              w_state_n = SETTLE;
              w_sel_n   = lowest_set(r_mask);
              w_valid_n = 1'b0;
            end else begin
              // An empty mask produces an all-zero frame immediately again.
              w_data_n  = '0;
              w_valid_n = 1'b1;
            end
          end else begin
            w_state_n = IDLE;
            w_valid_n = 1'b0;
            w_busy_n  = 1'b0;
            w_sel_n   = '0;
          end
        end
      end

      default: begin
        w_state_n = IDLE;
        w_sel_n   = '0;
        w_valid_n = 1'b0;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign sel         = r_sel;
  assign frame_data  = r_data;
  assign frame_valid = r_valid;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_mux_scan_ctrl : directed vector bench for mux_scan_ctrl.               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int DWELL = 2;
  localparam int LIMIT = 200;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cont;
  logic [15:0] chan_mask;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;

  logic [15:0] pattern;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] pat;
    logic [15:0] exp_data;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .chan_mask   (chan_mask),
    .mux_out     (mux_out),
    .sel         (sel),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy)
  );

  // Behaves like the downstream 16:1 mux.
  assign mux_out = pattern[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits (from a negedge) for frame_valid, recording sel occupancy; returns latency.
  task automatic wait_frame(output int lat, output logic [15:0] visited,
                            output logic stable, output logic busy_ok);
    int hist [16];
    lat     = 0;
    visited = '0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    while (1) begin
      @(negedge clk);
      if (frame_valid) break;
      hist[sel]++;
      if (!busy) busy_ok = 1'b0;
      if (lat > LIMIT) begin
        lat = -1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    for (int i = 0; i < 16; i++) begin
      if (hist[i] != 0) visited[i] = 1'b1;
      if (hist[i] != 0 && hist[i] != DWELL) stable = 1'b0;
    end
  endtask

  task automatic kick(input logic [15:0] m);
    @(negedge clk);
    chan_mask = m;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called at a negedge with frame_valid high; completes a non-continuous handshake.
  task automatic finish_frame(input string name);
    cont        = 1'b0;
    frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_idle_valid"}, {31'b0, frame_valid}, 32'd0);
    chk({name, "_idle_sel"}, {28'b0, sel}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] visited;
    logic        stable;
    logic        busy_ok;
    logic        hold_ok;

    checks = 0;
    errors = 0;

    vecs[0] = '{16'hFFFF, 16'hA5C3, 16'hA5C3, 32};
    vecs[1] = '{16'h8101, 16'hFFFF, 16'h8101, 6};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 0};
    vecs[3] = '{16'h0F0F, 16'h3C3C, 16'h0C0C, 16};
    vecs[4] = '{16'h0001, 16'h0001, 16'h0001, 2};
    vecs[5] = '{16'h8000, 16'h8000, 16'h8000, 2};
    vecs[6] = '{16'h5555, 16'hFFFF, 16'h5555, 16};

    rst         = 1'b1;
    start       = 1'b0;
    cont        = 1'b0;
    chan_mask   = '0;
    frame_ready = 1'b0;
    pattern     = '0;

    #12;
    chk("rst_sel",   {28'b0, sel},         32'd0);
    chk("rst_data",  {16'b0, frame_data},  32'd0);
    chk("rst_valid", {31'b0, frame_valid}, 32'd0);
    chk("rst_busy",  {31'b0, busy},        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table of single-shot scans.
    for (int v = 0; v < 7; v++) begin
      pattern = vecs[v].pat;
      kick(vecs[v].mask);
      wait_frame(lat, visited, stable, busy_ok);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_data", v), {16'b0, frame_data}, {16'b0, vecs[v].exp_data});
      chk($sformatf("v%0d_visited", v), {16'b0, visited},
          {16'b0, (vecs[v].mask == 16'h0) ? 16'h0000 : vecs[v].mask});
      chk($sformatf("v%0d_dwell", v), {31'b0, stable}, 32'd1);
      chk($sformatf("v%0d_busy", v), {31'b0, busy_ok & busy}, 32'd1);
      finish_frame($sformatf("v%0d", v));
    end

    // Backpressure: frame, sel and valid hold; a start pulse is ignored.
    pattern = 16'h00A0;
    kick(16'h00F0);
    wait_frame(lat, visited, stable, busy_ok);
    chk("bp_latency", lat, 8);
    chk("bp_data", {16'b0, frame_data}, 32'h00A0);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pattern = ~pattern;
      if (i == 3) begin
        chan_mask = 16'hFFFF;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (!frame_valid || frame_data !== 16'h00A0 || sel !== 4'd7 || !busy) hold_ok = 1'b0;
    end
    start = 1'b0;
    chk("bp_hold", {31'b0, hold_ok}, 32'd1);
    finish_frame("bp");

    // Continuous mode: back-to-back frames, rescan entered on the handshake edge.
    pattern = 16'h0001;
    kick(16'h0003);
    wait_frame(lat, visited, stable, busy_ok);
    chk("cont_f1_data", {16'b0, frame_data}, 32'h0001);
    cont        = 1'b1;
    frame_ready = 1'b1;
    pattern     = 16'h0002;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    cont = 1'b0;
    @(negedge clk);
    chk("cont_rescan_valid", {31'b0, frame_valid}, 32'd0);
    chk("cont_rescan_busy",  {31'b0, busy},        32'd1);
    chk("cont_rescan_sel",   {28'b0, sel},         32'd0);
    @(posedge clk);
    wait_frame(lat, visited, stable, busy_ok);
    chk("cont_f2_latency", lat + 1, 4);
    chk("cont_f2_data", {16'b0, frame_data}, 32'h0002);
    finish_frame("cont");

    // Asynchronous reset mid-scan, then a clean full frame.
    pattern = 16'hFFFF;
    kick(16'hFFFF);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_rst_sel", {28'b0, sel}, 32'd4);
    rst = 1'b1;
    #1;
    chk("arst_sel",   {28'b0, sel},         32'd0);
    chk("arst_data",  {16'b0, frame_data},  32'd0);
    chk("arst_valid", {31'b0, frame_valid}, 32'd0);
    chk("arst_busy",  {31'b0, busy},        32'd0);
    @(negedge clk);
    rst     = 1'b0;
    pattern = 16'h1234;
    kick(16'hFFFF);
    wait_frame(lat, visited, stable, busy_ok);
    chk("post_rst_latency", lat, 32);
    chk("post_rst_data", {16'b0, frame_data}, 32'h1234);
    finish_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequential scan controller that sits directly upstream of the 16:1 bit-select mux.
- Drives the mux's 4-bit select through every enabled channel and waits a programmable settle time on each.
- Samples the mux's 1-bit output on each channel and assembles the 16 sampled bits into a frame word.
- Hands the frame downstream on a valid/ready handshake. Supports single-shot and continuous scanning.

Parameters:
- DWELL, 2, cycles that sel is held on each channel before sampling. Legal range 1..255.
- CNT_W, 8, width of the dwell counter. Must satisfy DWELL <= 2**CNT_W - 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at each frame handshake.
- chan_mask  input  16  enabled channels; latched on the accepted start.
- mux_out  input  1  1-bit output of the downstream mux.
- sel  output  4  channel select driven to the mux.
- frame_data  output  16  assembled frame; bit i = sample of channel i.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts the frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, sel=0, frame_data=0, frame_valid=0, busy=0, dwell counter=0, latched mask=0, shadow register=0.
- States: IDLE, SETTLE, PRESENT. All outputs are registered.
- IDLE:
  - sel=0.
  - start=1 at an edge: latch chan_mask, clear shadow.
  - Latched mask nonzero: go to SETTLE with sel = lowest set bit and cnt=0.
  - Latched mask zero: go straight to PRESENT with frame_data=0.
- SETTLE:
  - cnt increments each edge.
  - At the edge where cnt==DWELL-1: shadow[sel] <= mux_out, which captures the value present during the final dwell cycle.
  - If a higher enabled channel exists: sel <= next enabled index, cnt <= 0.
  - Otherwise: frame_data <= shadow with the captured bit merged in, frame_valid <= 1, state <= PRESENT.
  - Masked-off channels are never visited; their frame bits are 0.
- Timing:
  - Channel k (k-th enabled channel, k from 0) is captured at edge (k+1)*DWELL after the start edge.
  - frame_valid rises after edge N*DWELL, where N = popcount(mask).
  - sel changes only at channel advance; it is stable for exactly DWELL cycles per channel.
- PRESENT:
  - frame_valid=1; frame_data held stable until the handshake (frame_valid & frame_ready at an edge).
  - Handshake with cont=0: frame_valid <= 0, go to IDLE.
  - Handshake with cont=1: frame_valid <= 0, rescan with the same latched mask (SETTLE at the first channel, or PRESENT again if the mask is 0). No IDLE cycle is inserted.
- No overrun is possible: scanning stalls in PRESENT under backpressure.
- start is ignored while busy.
- chan_mask changes during a scan are ignored until the next accepted start.
- frame_ready while frame_valid=0 has no effect.
- rst asserted mid-scan or mid-PRESENT: the frame is discarded and there is no partial output.
- Widths: the next-channel search is over the 16-bit latched mask above the current sel. There is no wrap-around within a frame; scans always run ascending from 0 to 15.

Decomposition:
- Shared package mux_scan_pkg:
  - NCH=16, SEL_W=4.
  - State enum (IDLE, SETTLE, PRESENT).
  - Function returning the lowest set bit index of a 16-bit vector.
- One sub-module, chan_next_find: combinational. Inputs mask[15:0] and cur[3:0]. Outputs nxt[3:0] = lowest enabled index > cur, and found = 1 if one exists.

Test Plan:
- DWELL=2, mask=16'hFFFF, mux input pattern 16'hA5C3, start pulse:
  - sel steps 0..15, each held 2 cycles.
  - frame_valid rises after edge 32, frame_data=16'hA5C3, busy=1 throughout.
- mask=16'h8101, pattern 16'hFFFF:
  - sel visits only 0, 8, 15.
  - frame_data=16'h8101 after 6 edges.
- mask=16'h0000, start:
  - PRESENT after 1 edge, frame_data=0.
  - sel never leaves 0.
- Backpressure: frame_ready=0 for 10 cycles after frame_valid.
  - frame_valid and frame_data hold; sel holds; a start pulse is ignored.
  - With ready=1 and cont=0: IDLE next cycle, busy=0.
- cont=1 with mask=16'h0003, pattern toggled between frames:
  - Back-to-back frames; SETTLE entered on the handshake edge; second frame reflects the new pattern.
- rst asserted asynchronously at edge 9 of a full scan:
  - All outputs clear immediately, without waiting for a clock edge.
  - A subsequent start yields a correct full frame with no stale bits.
